// File: rtl/odd_reg_fetch.sv
// Operand fetch for the odd (shift/rotate) pipe: register file, forwarding
// network, two-deep in-flight scoreboard and the registered operand bundle.
package defines_pkg;
  localparam int OPCODE_LEN = 11;
  typedef logic [OPCODE_LEN-1:0] Opcodes;
  localparam Opcodes LNOP = 11'b000_0000_0001;
endpackage

module odd_reg_fetch
  import defines_pkg::*;
#(
  parameter int REG_ADDR_WD = 7,
  parameter int REG_DATA_WD = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  Opcodes                 dec_opcode,
  input  logic [REG_ADDR_WD-1:0] dec_ra_addr,
  input  logic [REG_ADDR_WD-1:0] dec_rb_addr,
  input  logic [REG_ADDR_WD-1:0] dec_rc_addr,
  input  logic [REG_ADDR_WD-1:0] dec_rt_addr,
  input  logic                   dec_rt_we,
  input  logic [6:0]             dec_I7,
  input  logic [7:0]             dec_I8,
  input  logic [9:0]             dec_I10,
  input  logic [15:0]            dec_I16,
  input  logic [17:0]            dec_I18,
  input  logic [REG_ADDR_WD-1:0] fwd_addr_s2,
  input  logic [REG_ADDR_WD-1:0] fwd_addr_s3,
  input  logic [REG_ADDR_WD-1:0] fwd_addr_s4,
  input  logic [REG_ADDR_WD-1:0] fwd_addr_s5,
  input  logic [REG_ADDR_WD-1:0] fwd_addr_s6,
  input  logic [REG_ADDR_WD-1:0] fwd_addr_s7,
  input  logic [REG_DATA_WD-1:0] fwd_data_s2,
  input  logic [REG_DATA_WD-1:0] fwd_data_s3,
  input  logic [REG_DATA_WD-1:0] fwd_data_s4,
  input  logic [REG_DATA_WD-1:0] fwd_data_s5,
  input  logic [REG_DATA_WD-1:0] fwd_data_s6,
  input  logic [REG_DATA_WD-1:0] fwd_data_s7,
  input  logic [5:0]             fwd_we,
  input  logic                   wb_we,
  input  logic [REG_ADDR_WD-1:0] wb_addr,
  input  logic [REG_DATA_WD-1:0] wb_data,
  output Opcodes                 opcode,
  output logic [REG_DATA_WD-1:0] in_RA,
  output logic [REG_DATA_WD-1:0] in_RB,
  output logic [REG_DATA_WD-1:0] in_RC,
  output logic [6:0]             in_I7,
  output logic [7:0]             in_I8,
  output logic [9:0]             in_I10,
  output logic [15:0]            in_I16,
  output logic [17:0]            in_I18,
  output logic [REG_ADDR_WD-1:0] in_RT_addr,
  output logic                   out_valid
);

  localparam int NREG = 1 << REG_ADDR_WD;

  logic [REG_DATA_WD-1:0] rf [NREG];
  logic [REG_ADDR_WD-1:0] fa [6];
  logic [REG_DATA_WD-1:0] fd [6];
  logic [REG_ADDR_WD-1:0] src_addr [3];
  logic [REG_DATA_WD-1:0] src_data [3];
  logic                   sb0_valid, sb1_valid;
  logic [REG_ADDR_WD-1:0] sb0_addr, sb1_addr;
  logic                   hazard;
  logic                   accept;

  assign fa[0] = fwd_addr_s2;
  assign fa[1] = fwd_addr_s3;
  assign fa[2] = fwd_addr_s4;
  assign fa[3] = fwd_addr_s5;
  assign fa[4] = fwd_addr_s6;
  assign fa[5] = fwd_addr_s7;
  assign fd[0] = fwd_data_s2;
  assign fd[1] = fwd_data_s3;
  assign fd[2] = fwd_data_s4;
  assign fd[3] = fwd_data_s5;
  assign fd[4] = fwd_data_s6;
  assign fd[5] = fwd_data_s7;

  assign src_addr[0] = dec_ra_addr;
  assign src_addr[1] = dec_rb_addr;
  assign src_addr[2] = dec_rc_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Oldest source applied first so younger stages overwrite it.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      src_data[s] = rf[src_addr[s]];
      if (wb_we && wb_addr == src_addr[s]) src_data[s] = wb_data;
      for (int k = 5; k >= 0; k--) begin
        if (fwd_we[k] && fa[k] == src_addr[s]) src_data[s] = fd[k];
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (sb0_valid && sb0_addr == src_addr[s]) hazard = 1'b1;
      if (sb1_valid && sb1_addr == src_addr[s]) hazard = 1'b1;
    end
    hazard = hazard && dec_valid;
  end

  assign dec_ready = !hazard;
  assign accept    = dec_valid && dec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb0_valid <= 1'b0;
      sb0_addr  <= '0;
      sb1_valid <= 1'b0;
      sb1_addr  <= '0;
    end else begin
      sb1_valid <= sb0_valid;
      sb1_addr  <= sb0_addr;
      sb0_valid <= accept && dec_rt_we;
      sb0_addr  <= accept ? dec_rt_addr : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode     <= LNOP;
      in_RA      <= '0;
      in_RB      <= '0;
      in_RC      <= '0;
      in_I7      <= '0;
      in_I8      <= '0;
      in_I10     <= '0;
      in_I16     <= '0;
      in_I18     <= '0;
      in_RT_addr <= '0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      opcode     <= dec_opcode;
      in_RA      <= src_data[0];
      in_RB      <= src_data[1];
      in_RC      <= src_data[2];
      in_I7      <= dec_I7;
      in_I8      <= dec_I8;
      in_I10     <= dec_I10;
      in_I16     <= dec_I16;
      in_I18     <= dec_I18;
      in_RT_addr <= dec_rt_addr;
      out_valid  <= 1'b1;
    end else begin
      opcode     <= LNOP;
      in_RA      <= '0;
      in_RB      <= '0;
      in_RC      <= '0;
      in_I7      <= '0;
      in_I8      <= '0;
      in_I10     <= '0;
      in_I16     <= '0;
      in_I18     <= '0;
      in_RT_addr <= '0;
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/odd_reg_fetch.md
# odd_reg_fetch

Operand-fetch stage directly upstream of the odd (shift/rotate) pipe. It accepts one decoded odd-pipe instruction per cycle and reads RA/RB/RC from a 128 x 128-bit register file. Operands are forwarded from odd-pipe stages s2..s7 and from writeback. The result is a registered operand bundle driven into the odd pipe, and a 2-entry scoreboard stalls the decoder when a source register is still in flight and not yet forwardable.

## Interface
- OPCODE_LEN, 11, opcode width (defines_pkg Opcodes).
- REG_ADDR_WD, 7, register address width (128 registers).
- REG_DATA_WD, 128, register data width.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- dec_valid  in  1  decoder presents an instruction.
- dec_ready  out  1  block accepts the instruction this cycle.
- dec_opcode  in  Opcodes  decoded odd-pipe opcode.
- dec_ra_addr, dec_rb_addr, dec_rc_addr, dec_rt_addr  in  7 each  source and target register addresses.
- dec_rt_we  in  1  instruction writes RT.
- dec_I7, dec_I8, dec_I10, dec_I16, dec_I18  in  7/8/10/16/18  immediates.
- fwd_addr_s2..s7  in  7 each  odd-pipe stage target addresses.
- fwd_data_s2..s7  in  128 each  odd-pipe stage results.
- fwd_we  in  6  per-stage write enables from odd pipe; bit0 = s2 ... bit5 = s7.
- wb_we  in  1  writeback enable (odd pipe rt_wr_en_op).
- wb_addr  in  7  writeback address (odd pipe out_RT_addr).
- wb_data  in  128  writeback data (odd pipe out_RT).
- opcode  out  Opcodes  to odd pipe.
- in_RA, in_RB, in_RC  out  128 each  forwarded operands.
- in_I7, in_I8, in_I10, in_I16, in_I18  out  immediates, registered.
- in_RT_addr  out  7  target address.
- out_valid  out  1  bundle on outputs is a real instruction.

## Operation
- Register file: 128 entries, one write port (wb_*), three combinational read ports. Async reset clears all entries to 0.
- Operand select per source, in priority order, youngest first:
  - s2 (fwd_we[0] and addr match);
  - s3, s4, s5, s6, s7;
  - wb (wb_we and wb_addr match; this is the same-cycle write-through bypass);
  - register-file contents.
- Scoreboard: two entries, age0 and age1, each holding {valid, addr}.
  - Each cycle: age1 <= age0; age0 <= {accepted && dec_rt_we, dec_rt_addr}.
  - When nothing is accepted, age0 is loaded invalid.
- Hazard: dec_valid, and RA, RB or RC matches a valid age0 or age1 addr.
  - All three sources are compared regardless of opcode.
  - A producer is forwardable only from s2 onward, which is 3 cycles after its accept.
- dec_ready = !hazard. Accept = dec_valid && dec_ready.
- Output register on every clock:
  - On accept: load opcode, operands, immediates, in_RT_addr; out_valid=1.
  - Otherwise: opcode=LNOP, operands/immediates/in_RT_addr=0, out_valid=0. The odd pipe then sees a no-op and writes nothing.
- A stall holds no decoder state internally; the decoder must hold dec_* stable while dec_valid && !dec_ready.

## Timing
- Reset, asynchronous:
  - opcode=LNOP; all other outputs 0; out_valid=0;
  - scoreboard entries invalid; register file cleared.
  - dec_ready is combinational and is therefore 1 during reset whenever no hazard exists; nothing is accepted while rst=1.
- Latency: accept in cycle t puts the operand bundle on the outputs in cycle t+1.
- Dependent back-to-back instructions, consumer presented at t+1:
  - t+1: stall (producer in age0);
  - t+2: stall (producer in age1);
  - t+3: accept, forwarding from s2.
- Independent instructions: one accept per cycle, no bubbles.
- Write to register 0..127 in cycle t is readable from the file from t+1 and via bypass in t.
- Reset asserted mid-stall: scoreboard clears immediately. After deassertion the held instruction is accepted with register-file (zero) operands.

## Test plan
- Reset: assert rst with dec_valid=1 -> all outputs 0, opcode=LNOP, out_valid=0. Every register reads 0 after release.
- Writeback bypass: wb_we=1, wb_addr=5, wb_data=0xA5..A5 while accepting RA=5 -> in_RA=0xA5..A5 next cycle. A later read of r5 without wb also returns 0xA5..A5.
- Forward priority: s2 and s5 both target r9 with data 0x1 and 0x2, wb targets r9 with 0x3 -> in_RB=0x1. Drop fwd_we[0] -> 0x2.
- RAW stall: accept RT=12 (we=1) at t; present RA=12 at t+1 -> dec_ready=0 at t+1 and t+2, accepted t+3. Output bubbles carry out_valid=0 and LNOP.
- No false stall: producer with dec_rt_we=0 targeting r12, consumer RA=12 next cycle -> accepted immediately.
- Throughput: 20 independent instructions with dec_valid held high -> 20 consecutive out_valid=1 cycles; immediates and RT addresses are passed through exactly.
